div_job_sequencer: RTL and testbench

- Sits directly upstream of the sequential divider controller/datapath. It accepts division jobs from a valid/ready stream and holds the operands on the divider inputs.
- It drives the divider's start handshake and tracks busy, valid and ovf. It classifies each job's outcome as OK, divide-by-zero, overflow or timeout.
- Each result is presented on a valid/ready output stream with backpressure.

---
 rtl/div_job_sequencer.sv | 157 +++++++++++++++
 tb/tb_div_job_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_job_sequencer.sv
// Job sequencer in front of a sequential divider.
// Accepts one division job at a time, holds the operands on the divider
// inputs, drives the start handshake, classifies the outcome and presents
// it on an output stream that may be backpressured.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1; valid never waits on ready, and once raised stays high with
// stable payload until the transfer.
module div_job_sequencer #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_busy,
    input  logic             div_valid,
    input  logic             div_ovf,
    input  logic [WIDTH-1:0] div_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [1:0]       out_status,
    output logic [CNT_W-1:0] jobs_done,
    output logic [1:0]       fsm_state
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_DVZ = 2'b01;
    localparam logic [1:0] ST_OVF = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, RUN, RESULT} state_t;

    state_t           state;
    state_t           state_next;
    logic [TW-1:0]    timer;
    logic             flag_v;
    logic             flag_o;
    logic [WIDTH-1:0] q_cap;

    // Flag values including this cycle's divider pulses.
    logic             v_now;
    logic             o_now;
    logic [WIDTH-1:0] q_now;
    logic             timer_last;
    logic             done_run;
    logic             timeout_hit;

    // Ready only in IDLE and never while reset is held; depends on state only.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == RESULT);
    assign fsm_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic plus completion / timeout decode.
    always_comb begin
        v_now       = flag_v | div_valid;
        o_now       = flag_o | div_ovf;
        q_now       = div_valid ? div_q : q_cap;
        timer_last  = (timer == TW'(TIMEOUT - 1));
        done_run    = (state == RUN) && !div_busy;
        // Completion in the same cycle as the last timer value wins.
        timeout_hit = ((state == ISSUE) || (state == RUN)) && timer_last && !done_run;
        state_next  = state;
        case (state)
            IDLE:    if (in_valid) state_next = ISSUE;
            ISSUE: begin
                if (timeout_hit)   state_next = RESULT;
                else if (div_busy) state_next = RUN;
            end
            RUN:     if (done_run || timeout_hit) state_next = RESULT;
            RESULT:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand, flag, timer, result and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_start  <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
            out_q      <= '0;
            out_status <= ST_OK;
            jobs_done  <= '0;
            flag_v     <= 1'b0;
            flag_o     <= 1'b0;
            q_cap      <= '0;
            timer      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        div_a     <= in_a;
                        div_b     <= in_b;
                        flag_v    <= 1'b0;
                        flag_o    <= 1'b0;
                        q_cap     <= '0;
                        timer     <= '0;
                        div_start <= 1'b1;
                    end
                end
                ISSUE: begin
                    timer <= timer + TW'(1);
                    if (timeout_hit) begin
                        div_start  <= 1'b0;
                        out_status <= ST_TMO;
                        out_q      <= '0;
                    end else if (div_busy) begin
                        div_start <= 1'b0;
                    end
                end
                RUN: begin
                    timer  <= timer + TW'(1);
                    flag_v <= v_now;
                    flag_o <= o_now;
                    q_cap  <= q_now;
                    if (done_run) begin
                        if (o_now) begin
                            out_status <= ST_OVF;
                            out_q      <= '0;
                        end else if (v_now) begin
                            out_status <= ST_OK;
                            out_q      <= q_now;
                        end else begin
                            out_status <= ST_DVZ;
                            out_q      <= '0;
                        end
                    end else if (timeout_hit) begin
                        out_status <= ST_TMO;
                        out_q      <= '0;
                    end
                end
                RESULT: begin
                    if (out_ready) jobs_done <= jobs_done + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_job_sequencer.sv
// Self-checking bench for div_job_sequencer with a behavioural divider model
// and a scoreboard of expected {status, quotient} results.
module tb_div_job_sequencer;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             div_start;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             div_busy;
    logic             div_valid;
    logic             div_ovf;
    logic [WIDTH-1:0] div_q;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_q;
    logic [1:0]       out_status;
    logic [CNT_W-1:0] jobs_done;
    logic [1:0]       fsm_state;

    logic [WIDTH+1:0] exp_q[$];
    logic [WIDTH+1:0] exp;
    logic [CNT_W-1:0] exp_jobs = '0;
    int               n_checks = 0;
    int               n_pass   = 0;

    // Clock and DUT.
    always #5 clk = ~clk;

    div_job_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_busy(div_busy), .div_valid(div_valid), .div_ovf(div_ovf), .div_q(div_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q),
        .out_status(out_status), .jobs_done(jobs_done), .fsm_state(fsm_state)
    );

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        step();
        in_valid = 1'b0;
    endtask

    // Divider model: busy for busy_cycles cycles (the first one is seen in
    // ISSUE), then one busy-low cycle. valid/ovf pulse at the given index;
    // index busy_cycles means the pulse coincides with busy falling.
    task automatic divider_respond(input int busy_cycles, input int valid_at,
                                   input int ovf_at, input logic [WIDTH-1:0] q);
        for (int i = 0; i < busy_cycles; i++) begin
            div_busy  = 1'b1;
            div_valid = (i == valid_at);
            div_ovf   = (i == ovf_at);
            div_q     = (i == valid_at) ? q : WIDTH'($urandom_range(0, 255));
            step();
        end
        div_busy  = 1'b0;
        div_valid = (valid_at == busy_cycles);
        div_ovf   = (ovf_at == busy_cycles);
        div_q     = (valid_at == busy_cycles) ? q : WIDTH'($urandom_range(0, 255));
        step();
        div_valid = 1'b0;
        div_ovf   = 1'b0;
    endtask

    // Expected outcome derived from the divider model's behaviour.
    function automatic logic [WIDTH+1:0] model(input int busy_cycles, input int valid_at,
                                               input int ovf_at, input logic [WIDTH-1:0] q);
        bit v, o;
        if (busy_cycles >= TIMEOUT) return {2'b11, {WIDTH{1'b0}}};
        v = (valid_at >= 1) && (valid_at <= busy_cycles);
        o = (ovf_at >= 1) && (ovf_at <= busy_cycles);
        if (o) return {2'b10, {WIDTH{1'b0}}};
        if (v) return {2'b00, q};
        return {2'b01, {WIDTH{1'b0}}};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;
        div_busy = 0; div_valid = 0; div_ovf = 0; div_q = 0;
        step();
        step();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || div_start !== 1'b0)
            $display("FAIL reset_hold: in_ready=%0b out_valid=%0b div_start=%0b expected 0 0 0",
                     in_ready, out_valid, div_start);
        else n_pass++;
        n_checks++;
        if (jobs_done !== '0 || div_a !== '0 || div_b !== '0 || out_q !== '0 || out_status !== 2'b00)
            $display("FAIL reset_clear: jobs=%0d a=%0d b=%0d q=%0d st=%0d expected all 0",
                     jobs_done, div_a, div_b, out_q, out_status);
        else n_pass++;
        rst = 1'b0;
        step();
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_idle_ready: in_ready=%0b expected 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_ok();
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL ok_ready: in_ready=%0b expected 1", in_ready);
        else n_pass++;
        exp_q.push_back(model(4, 3, -1, 8'd14));
        launch(8'd100, 8'd7);
        n_checks++;
        if (div_start !== 1'b1 || div_a !== 8'd100 || div_b !== 8'd7 || in_ready !== 1'b0)
            $display("FAIL ok_issue: start=%0b a=%0d b=%0d ready=%0b expected 1 100 7 0",
                     div_start, div_a, div_b, in_ready);
        else n_pass++;
        divider_respond(4, 3, -1, 8'd14);
        exp = exp_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || {out_status, out_q} !== exp)
            $display("FAIL ok_result: valid=%0b st=%0d q=%0d expected 1 %0d %0d",
                     out_valid, out_status, out_q, exp[WIDTH+1:WIDTH], exp[WIDTH-1:0]);
        else n_pass++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_jobs++;
        n_checks++;
        if (jobs_done !== exp_jobs || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL ok_done: jobs=%0d valid=%0b ready=%0b expected %0d 0 1",
                     jobs_done, out_valid, in_ready, exp_jobs);
        else n_pass++;
    endtask

    task automatic test_dvz();
        exp_q.push_back({2'b01, {WIDTH{1'b0}}});
        launch(8'd9, 8'd0);
        n_checks++;
        if (div_start !== 1'b1) $display("FAIL dvz_start_on: div_start=%0b expected 1", div_start);
        else n_pass++;
        div_busy = 1'b1;
        step();
        n_checks++;
        if (div_start !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL dvz_start_off: div_start=%0b out_valid=%0b expected 0 0", div_start, out_valid);
        else n_pass++;
        div_busy = 1'b0;
        step();
        exp = exp_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || {out_status, out_q} !== exp)
            $display("FAIL dvz_result: valid=%0b st=%0d q=%0d expected 1 %0d %0d",
                     out_valid, out_status, out_q, exp[WIDTH+1:WIDTH], exp[WIDTH-1:0]);
        else n_pass++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_jobs++;
        n_checks++;
        if (jobs_done !== exp_jobs) $display("FAIL dvz_done: jobs=%0d expected %0d", jobs_done, exp_jobs);
        else n_pass++;
    endtask

    // Overflow alone, overflow with valid, and the completion/timeout races.
    task automatic test_ovf_and_boundary();
        int bc[4] = '{3, 4, 63, 64};
        int va[4] = '{-1, 2, 63, 63};
        int oa[4] = '{1, 1, -1, -1};
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(model(bc[k], va[k], oa[k], 8'h5A));
            launch(8'd200, 8'd1);
            divider_respond(bc[k], va[k], oa[k], 8'h5A);
            exp = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || {out_status, out_q} !== exp)
                $display("FAIL ovf_case%0d: valid=%0b st=%0d q=%0h expected 1 %0d %0h", k,
                         out_valid, out_status, out_q, exp[WIDTH+1:WIDTH], exp[WIDTH-1:0]);
            else n_pass++;
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            exp_jobs++;
        end
        n_checks++;
        if (jobs_done !== exp_jobs) $display("FAIL ovf_done: jobs=%0d expected %0d", jobs_done, exp_jobs);
        else n_pass++;
    endtask

    task automatic test_issue_timeout();
        exp_q.push_back({2'b11, {WIDTH{1'b0}}});
        launch(8'd5, 8'd3);
        for (int i = 1; i < TIMEOUT; i++) step();
        n_checks++;
        if (out_valid !== 1'b0 || div_start !== 1'b1)
            $display("FAIL tmo_early: valid=%0b start=%0b expected 0 1", out_valid, div_start);
        else n_pass++;
        step();
        exp = exp_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || {out_status, out_q} !== exp || div_start !== 1'b0)
            $display("FAIL tmo_result: valid=%0b st=%0d q=%0d start=%0b expected 1 3 0 0",
                     out_valid, out_status, out_q, div_start);
        else n_pass++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_jobs++;
        n_checks++;
        if (jobs_done !== exp_jobs || div_start !== 1'b0)
            $display("FAIL tmo_done: jobs=%0d start=%0b expected %0d 0", jobs_done, div_start, exp_jobs);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [CNT_W-1:0] jobs_before;
        exp_q.push_back(model(2, 2, -1, 8'd10));
        launch(8'd50, 8'd5);
        divider_respond(2, 2, -1, 8'd10);
        exp = exp_q.pop_front();
        jobs_before = jobs_done;
        exp_q.push_back(model(3, 3, -1, 8'd4));
        in_valid = 1'b1;
        in_a = 8'd33;
        in_b = 8'd8;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_status, out_q} !== exp ||
                div_a !== 8'd50 || jobs_done !== jobs_before)
                $display("FAIL bp_hold%0d: ready=%0b valid=%0b st=%0d q=%0d a=%0d jobs=%0d expected 0 1 %0d %0d 50 %0d",
                         i, in_ready, out_valid, out_status, out_q, div_a, jobs_done,
                         exp[WIDTH+1:WIDTH], exp[WIDTH-1:0], jobs_before);
            else n_pass++;
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_jobs++;
        n_checks++;
        if (jobs_done !== exp_jobs || in_ready !== 1'b1 || div_a !== 8'd50)
            $display("FAIL bp_release: jobs=%0d ready=%0b a=%0d expected %0d 1 50",
                     jobs_done, in_ready, div_a, exp_jobs);
        else n_pass++;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (div_a !== 8'd33 || div_start !== 1'b1 || jobs_done !== exp_jobs)
            $display("FAIL bp_second: a=%0d start=%0b jobs=%0d expected 33 1 %0d",
                     div_a, div_start, jobs_done, exp_jobs);
        else n_pass++;
        divider_respond(3, 3, -1, 8'd4);
        exp = exp_q.pop_front();
        n_checks++;
        if ({out_status, out_q} !== exp)
            $display("FAIL bp_second_result: st=%0d q=%0d expected %0d %0d",
                     out_status, out_q, exp[WIDTH+1:WIDTH], exp[WIDTH-1:0]);
        else n_pass++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_jobs++;
    endtask

    task automatic test_random_jobs();
        for (int k = 0; k < 10; k++) begin
            logic [WIDTH-1:0] a, b, q;
            int bc, va, oa, kind, wait_cyc;
            a    = WIDTH'($urandom_range(0, 255));
            b    = WIDTH'($urandom_range(1, 255));
            q    = a / b;
            bc   = $urandom_range(1, 8);
            kind = $urandom_range(0, 2);
            va   = (kind == 0) ? $urandom_range(1, bc) : -1;
            oa   = (kind == 2) ? $urandom_range(1, bc) : -1;
            if (kind == 1) b = '0;
            exp_q.push_back(model(bc, va, oa, q));
            launch(a, b);
            divider_respond(bc, va, oa, q);
            wait_cyc = $urandom_range(0, 3);
            for (int w = 0; w < wait_cyc; w++) step();
            exp = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || {out_status, out_q} !== exp)
                $display("FAIL rand%0d: valid=%0b st=%0d q=%0d expected 1 %0d %0d", k,
                         out_valid, out_status, out_q, exp[WIDTH+1:WIDTH], exp[WIDTH-1:0]);
            else n_pass++;
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            exp_jobs++;
        end
        n_checks++;
        if (jobs_done !== exp_jobs) $display("FAIL rand_done: jobs=%0d expected %0d", jobs_done, exp_jobs);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        launch(8'd77, 8'd3);
        div_busy = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || div_start !== 1'b0)
            $display("FAIL rst_run_hold: ready=%0b valid=%0b start=%0b expected 0 0 0",
                     in_ready, out_valid, div_start);
        else n_pass++;
        rst = 1'b0;
        div_busy = 1'b0;
        exp_jobs = '0;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || div_start !== 1'b0 || jobs_done !== exp_jobs ||
            in_ready !== 1'b1 || div_a !== '0)
            $display("FAIL rst_run_after: valid=%0b start=%0b jobs=%0d ready=%0b a=%0d expected 0 0 0 1 0",
                     out_valid, div_start, jobs_done, in_ready, div_a);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ok();
        test_dvz();
        test_ovf_and_boundary();
        test_issue_timeout();
        test_backpressure();
        test_random_jobs();
        test_reset_mid_run();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_empty: left=%0d expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
